pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator. It succeeds the single-channel 16-bit PWM used for motor and servo drive on the car controller FPGA. All channels share one period counter. Each channel has its own duty, and the block adds edge- or center-aligned counting, per-channel output inversion, and glitch-free shadowed updates applied only at period boundaries. It sits between the host register interface and the motor/servo driver pins.

Parameters:
WIDTH, 16, bit width of counter, period and duty
CHANNELS, 4, number of PWM outputs sharing one counter
INV_MASK, {CHANNELS{1'b0}}, per-channel output inversion; bit i=1 makes channel i active-low

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
enable  in  1  1 = counter runs; 0 = counter held at 0 and outputs forced idle
upd_valid  in  1  update request; qualifies upd_period, upd_duty, upd_center
upd_ready  out  1  1 = no update pending, request can be accepted
upd_period  in  WIDTH  new period value
upd_duty  in  CHANNELS*WIDTH  new duties; channel i at bits [i*WIDTH +: WIDTH]
upd_center  in  1  new mode: 0 = edge-aligned, 1 = center-aligned
upd_done  out  1  one-cycle pulse when pending values become active
period_start  out  1  one-cycle pulse, registered, coincident with the first output cycle of each period
cnt_out  out  WIDTH  current counter value, for debug and ADC trigger
pwm_out  out  CHANNELS  PWM outputs

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - cnt=0, direction=up, active period=0, active duties=0, active mode=edge.
  - pending flag=0, upd_ready=1, upd_done=0, period_start=0.
  - pwm_out=INV_MASK (idle level).
- Reset mid-operation discards any pending update.
- Edge mode:
  - cnt counts 0,1,…,P, then back to 0. Period length is P+1 cycles.
  - Boundary = cycle where cnt==P.
- Center mode:
  - cnt counts 0 up to P, then down P-1,…,1, then back to 0. Period length is 2P cycles.
  - Boundary = cycle where direction is down and cnt==1.
- P=0 (either mode): cnt stays 0 and every cycle is a boundary.
- Active-mode switch takes effect at a boundary. The counter always restarts at 0 counting up.
- Compare: raw_i = (cnt < duty_i), an unsigned WIDTH-bit compare.
  - duty_i=0 gives constant 0.
  - duty_i > P (edge) or duty_i ≥ P+1 gives constant 1.
  - Center mode: high time = 2·duty_i − 1 cycles for 1 ≤ duty_i ≤ P, centred on cnt=0.
- pwm_out[i] = raw_i XOR INV_MASK[i], registered. Latency is one cycle from cnt to pwm_out.
- period_start is registered with the same one-cycle latency, so it aligns with the output cycle for cnt=0.
- Update handshake:
  - Accept when upd_valid && upd_ready. Capture upd_period, upd_duty and upd_center into pending registers; pending=1; upd_ready=0 on the next cycle.
  - upd_valid without upd_ready is ignored; the source must hold it.
  - At a boundary with pending=1: active ← pending, pending ← 0, upd_done=1 for one cycle, upd_ready=1 the next cycle. New values govern the cycle where cnt=0.
  - Accept and boundary in the same cycle: values are captured into pending and applied at the next boundary, never the current one.
- enable=0:
  - cnt ← 0, direction ← up, pwm_out ← INV_MASK, period_start=0.
  - Any pending update is applied on the next cycle, with an upd_done pulse.
  - Re-asserting enable starts the period at cnt=0.
- Arithmetic: wrap-free. cnt never exceeds P, so no overflow; P=2^WIDTH−1 is legal.

Decomposition:
- Package pwm_pkg:
  - mode enum (PWM_EDGE, PWM_CENTER)
  - direction enum
  - default WIDTH/CHANNELS constants
  - duty-slice helper function
- Sub-module pwm_timebase: counter, direction and boundary/period_start generation. It is shared by all channels.
- The compare/invert stage is a generate loop per channel in pwm_multi.

Test Plan:
- Edge basic: WIDTH=16, P=9, duty0=3, duty1=0, duty2=10, enable=1 -> ch0 high 3 of every 10 cycles; ch1 constant 0; ch2 constant 1; period_start every 10 cycles.
- Center: P=8, duty0=3, upd_center=1 -> period 16 cycles; ch0 high 5 cycles centred on cnt=0; cnt sequence 0..8..1.
- Shadow update: running P=9, duty0=3; write duty0=7 mid-period at cnt=4 -> current period keeps 3-cycle pulse; upd_done pulses at cnt==9; next period 7-cycle pulse; upd_ready low between accept and done.
- Simultaneous: upd_valid accepted in the boundary cycle -> applied one full period later; second request held while upd_ready=0 is accepted only after upd_done.
- Inversion/enable: INV_MASK=4'b0010, enable toggled low mid-period -> pwm_out=0010 next cycle, cnt=0; on re-enable, period restarts at cnt=0.
- Reset mid-op: rst_n=0 for one edge with an update pending -> all outputs at reset values, pending discarded, upd_done never pulses; P=0 afterwards gives constant idle and cnt=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block: counting mode,
// counter direction, default sizes and the packed duty-bus slice offset.
package pwm_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Channel ch occupies bits [ch*width +: width] of a packed duty bus.
  function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter: edge/center counting, boundary detect, period_start.
// cnt and boundary are combinational from state; period_start lags cnt==0 by one cycle.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  pwm_mode_e        mode,
  output logic [WIDTH-1:0] cnt,
  output logic             boundary,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  pwm_dir_e         dir_q, dir_d;
  logic             period_start_q, period_start_d;

  // P==1 in center mode never turns down, so its last cycle is cnt==1 going up.
  always_comb begin
    boundary = 1'b0;
    if (period == '0) begin
      boundary = 1'b1;
    end else if (mode == PWM_EDGE) begin
      boundary = (cnt_q == period);
    end else begin
      boundary = (cnt_q == ONE) && ((dir_q == DIR_DOWN) || (period == ONE));
    end
  end

  always_comb begin
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    period_start_d = enable && (cnt_q == '0);
    if (!enable || boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode == PWM_EDGE) begin
      cnt_d = cnt_q + ONE;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == period) begin
        cnt_d = cnt_q - ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      period_start_q <= period_start_d;
    end
  end

  assign cnt          = cnt_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shadowed period/duty/mode applied at period boundaries; pwm_out lags cnt by one cycle.
// Updates use valid/ready: one request may be pending, upd_ready drops until it is applied (upd_done).
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                  WIDTH    = DEF_WIDTH,
  parameter int                  CHANNELS = DEF_CHANNELS,
  parameter logic [CHANNELS-1:0] INV_MASK = {CHANNELS{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [WIDTH-1:0]          upd_period,
  input  logic [CHANNELS*WIDTH-1:0] upd_duty,
  input  logic                      upd_center,
  output logic                      upd_done,
  output logic                      period_start,
  output logic [WIDTH-1:0]          cnt_out,
  output logic [CHANNELS-1:0]       pwm_out
);

  logic                      pend_q, pend_d;
  logic [WIDTH-1:0]          pend_period_q, pend_period_d;
  logic [CHANNELS*WIDTH-1:0] pend_duty_q, pend_duty_d;
  pwm_mode_e                 pend_mode_q, pend_mode_d;

  logic [WIDTH-1:0]          period_q, period_d;
  logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
  pwm_mode_e                 mode_q, mode_d;

  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic [CHANNELS-1:0]       raw;
  logic [WIDTH-1:0]          cnt;
  logic                      boundary;
  logic                      accept;
  logic                      apply;

  // A stopped counter has no boundary to wait for, so pending values go live at once.
  assign accept = upd_valid && !pend_q;
  assign apply  = pend_q && (boundary || !enable);

  always_comb begin
    pend_d        = pend_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_mode_d   = pend_mode_q;
    period_d      = period_q;
    duty_d        = duty_q;
    mode_d        = mode_q;
    if (apply) begin
      period_d = pend_period_q;
      duty_d   = pend_duty_q;
      mode_d   = pend_mode_q;
      pend_d   = 1'b0;
    end
    if (accept) begin
      pend_d        = 1'b1;
      pend_period_d = upd_period;
      pend_duty_d   = upd_duty;
      pend_mode_d   = upd_center ? PWM_CENTER : PWM_EDGE;
    end
  end

  pwm_timebase #(
    .WIDTH(WIDTH)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period       (period_q),
    .mode         (mode_q),
    .cnt          (cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign raw[i] = (cnt < duty_q[duty_lsb(i, WIDTH) +: WIDTH]);
  end

  always_comb begin
    pwm_d = INV_MASK;
    if (enable) begin
      pwm_d = raw ^ INV_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q        <= 1'b0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_mode_q   <= PWM_EDGE;
      period_q      <= '0;
      duty_q        <= '0;
      mode_q        <= PWM_EDGE;
      pwm_q         <= INV_MASK;
    end else begin
      pend_q        <= pend_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_mode_q   <= pend_mode_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      mode_q        <= mode_d;
      pwm_q         <= pwm_d;
    end
  end

  assign upd_ready = !pend_q;
  assign upd_done  = apply;
  assign cnt_out   = cnt;
  assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: 4 channels, 16-bit, channel 1 inverted.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_pwm_multi;

  localparam int              W   = 16;
  localparam int              C   = 4;
  localparam logic [C-1:0]    INV = 4'b0010;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic           upd_valid;
  logic           upd_ready;
  logic [W-1:0]   upd_period;
  logic [C*W-1:0] upd_duty;
  logic           upd_center;
  logic           upd_done;
  logic           period_start;
  logic [W-1:0]   cnt_out;
  logic [C-1:0]   pwm_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi #(
    .WIDTH    (W),
    .CHANNELS (C),
    .INV_MASK (INV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_period   (upd_period),
    .upd_duty     (upd_duty),
    .upd_center   (upd_center),
    .upd_done     (upd_done),
    .period_start (period_start),
    .cnt_out      (cnt_out),
    .pwm_out      (pwm_out)
  );

  // Channels 1..3 keep duty 0 / 10 / 0 throughout; only channel 0 varies.
  task automatic drive_upd(input logic [W-1:0] p, input logic [W-1:0] d0, input logic ctr);
    upd_period = p;
    upd_duty   = {16'd0, 16'd10, 16'd0, d0};
    upd_center = ctr;
    upd_valid  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; upd_valid = 1'b0;
    upd_period = '0; upd_duty = '0; upd_center = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cnt_out !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_out); end
    checks++; if (pwm_out !== 4'b0010) begin errors++; $display("FAIL reset_pwm got %b exp 0010", pwm_out); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", upd_ready); end
    checks++; if (upd_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", upd_done); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b exp 0", period_start); end
    rst_n = 1'b1;
  endtask

  task automatic test_edge_basic();
    int hi;
    logic [W-1:0] ec;
    logic [C-1:0] ep;
    logic eps;
    @(negedge clk);
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL edge_ready_idle got %b exp 1", upd_ready); end
    drive_upd(16'd9, 16'd3, 1'b0);
    @(negedge clk);
    checks++; if (upd_done !== 1'b1) begin errors++; $display("FAIL edge_done_disabled got %b exp 1", upd_done); end
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL edge_ready_pend got %b exp 0", upd_ready); end
    upd_valid = 1'b0;
    @(negedge clk);
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL edge_ready_after got %b exp 1", upd_ready); end
    checks++; if (upd_done !== 1'b0) begin errors++; $display("FAIL edge_done_after got %b exp 0", upd_done); end
    enable = 1'b1;
    hi = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      ec  = W'(k % 10);
      ep  = {1'b0, 1'b1, 1'b1, ((k - 1) % 10) < 3};
      eps = (((k - 1) % 10) == 0);
      checks++; if (cnt_out !== ec) begin errors++; $display("FAIL edge_cnt k=%0d got %0d exp %0d", k, cnt_out, ec); end
      checks++; if (pwm_out !== ep) begin errors++; $display("FAIL edge_pwm k=%0d got %b exp %b", k, pwm_out, ep); end
      checks++; if (period_start !== eps) begin errors++; $display("FAIL edge_ps k=%0d got %b exp %b", k, period_start, eps); end
      if (k <= 10 && pwm_out[0]) hi++;
    end
    checks++; if (hi !== 3) begin errors++; $display("FAIL edge_high_count got %0d exp 3", hi); end
  endtask

  task automatic test_shadow();
    int hi_a, hi_b;
    logic er, ed;
    hi_a = 0; hi_b = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      er = !(j >= 5 && j <= 9);
      ed = (j == 9);
      checks++; if (upd_ready !== er) begin errors++; $display("FAIL shadow_ready j=%0d got %b exp %b", j, upd_ready, er); end
      checks++; if (upd_done !== ed) begin errors++; $display("FAIL shadow_done j=%0d got %b exp %b", j, upd_done, ed); end
      if (pwm_out[0]) begin
        if (j <= 10) hi_a++; else hi_b++;
      end
      if (j == 4) drive_upd(16'd9, 16'd7, 1'b0);
      if (j == 5) upd_valid = 1'b0;
    end
    checks++; if (hi_a !== 3) begin errors++; $display("FAIL shadow_old_pulse got %0d exp 3", hi_a); end
    checks++; if (hi_b !== 7) begin errors++; $display("FAIL shadow_new_pulse got %0d exp 7", hi_b); end
  endtask

  task automatic test_simultaneous();
    int hi [4];
    logic er, ed;
    for (int n = 0; n < 4; n++) hi[n] = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      er = !((j >= 10 && j <= 19) || (j >= 21 && j <= 29));
      ed = (j == 19) || (j == 29);
      checks++; if (upd_ready !== er) begin errors++; $display("FAIL simul_ready j=%0d got %b exp %b", j, upd_ready, er); end
      checks++; if (upd_done !== ed) begin errors++; $display("FAIL simul_done j=%0d got %b exp %b", j, upd_done, ed); end
      if (pwm_out[0]) hi[(j - 1) / 10]++;
      if (j == 9)  drive_upd(16'd9, 16'd2, 1'b0);
      if (j == 10) drive_upd(16'd9, 16'd5, 1'b0);
      if (j == 21) upd_valid = 1'b0;
    end
    checks++; if (hi[0] !== 7) begin errors++; $display("FAIL simul_p0 got %0d exp 7", hi[0]); end
    checks++; if (hi[1] !== 7) begin errors++; $display("FAIL simul_not_current got %0d exp 7", hi[1]); end
    checks++; if (hi[2] !== 2) begin errors++; $display("FAIL simul_first_applied got %0d exp 2", hi[2]); end
    checks++; if (hi[3] !== 5) begin errors++; $display("FAIL simul_second_applied got %0d exp 5", hi[3]); end
  endtask

  task automatic test_center();
    int tbl [16];
    int hi;
    logic [W-1:0] ec;
    logic e0, eps, ed;
    tbl = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};
    hi = 0;
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL center_ready got %b exp 1", upd_ready); end
    drive_upd(16'd8, 16'd3, 1'b1);
    for (int j = 1; j <= 27; j++) begin
      @(negedge clk);
      if (j == 1) upd_valid = 1'b0;
      ed = (j == 9);
      checks++; if (upd_done !== ed) begin errors++; $display("FAIL center_done j=%0d got %b exp %b", j, upd_done, ed); end
      if (j >= 10) begin
        ec = W'(tbl[(j - 10) % 16]);
        checks++; if (cnt_out !== ec) begin errors++; $display("FAIL center_cnt j=%0d got %0d exp %0d", j, cnt_out, ec); end
      end
      if (j >= 11) begin
        e0  = (tbl[(j - 11) % 16] < 3);
        eps = (((j - 11) % 16) == 0);
        checks++; if (pwm_out[0] !== e0) begin errors++; $display("FAIL center_pwm0 j=%0d got %b exp %b", j, pwm_out[0], e0); end
        checks++; if (pwm_out[2] !== 1'b1) begin errors++; $display("FAIL center_pwm2 j=%0d got %b exp 1", j, pwm_out[2]); end
        checks++; if (period_start !== eps) begin errors++; $display("FAIL center_ps j=%0d got %b exp %b", j, period_start, eps); end
        if (j <= 26 && pwm_out[0]) hi++;
      end
    end
    checks++; if (hi !== 5) begin errors++; $display("FAIL center_high_count got %0d exp 5", hi); end
  endtask

  task automatic test_inv_enable();
    @(negedge clk);
    checks++; if (cnt_out !== 16'd2) begin errors++; $display("FAIL inv_cnt_before got %0d exp 2", cnt_out); end
    enable = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checks++; if (cnt_out !== 16'd0) begin errors++; $display("FAIL inv_cnt_off j=%0d got %0d exp 0", j, cnt_out); end
      checks++; if (pwm_out !== 4'b0010) begin errors++; $display("FAIL inv_pwm_off j=%0d got %b exp 0010", j, pwm_out); end
      checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL inv_ps_off j=%0d got %b exp 0", j, period_start); end
    end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (cnt_out !== 16'd1) begin errors++; $display("FAIL inv_cnt_re1 got %0d exp 1", cnt_out); end
    checks++; if (pwm_out !== 4'b0111) begin errors++; $display("FAIL inv_pwm_re1 got %b exp 0111", pwm_out); end
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL inv_ps_re1 got %b exp 1", period_start); end
    @(negedge clk);
    checks++; if (cnt_out !== 16'd2) begin errors++; $display("FAIL inv_cnt_re2 got %0d exp 2", cnt_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL inv_ps_re2 got %b exp 0", period_start); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (cnt_out !== 16'd4) begin errors++; $display("FAIL inv_cnt_re4 got %0d exp 4", cnt_out); end
    checks++; if (pwm_out !== 4'b0110) begin errors++; $display("FAIL inv_pwm_re4 got %b exp 0110", pwm_out); end
  endtask

  task automatic test_reset_midop();
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_pre got %b exp 1", upd_ready); end
    drive_upd(16'd5, 16'd4, 1'b0);
    @(negedge clk);
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", upd_ready); end
    upd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (cnt_out !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", cnt_out); end
    checks++; if (pwm_out !== 4'b0010) begin errors++; $display("FAIL rst_mid_pwm got %b exp 0010", pwm_out); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", upd_ready); end
    checks++; if (upd_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", upd_done); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_mid_ps got %b exp 0", period_start); end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      checks++; if (upd_done !== 1'b0) begin errors++; $display("FAIL rst_p0_done j=%0d got %b exp 0", j, upd_done); end
      checks++; if (cnt_out !== 16'd0) begin errors++; $display("FAIL rst_p0_cnt j=%0d got %0d exp 0", j, cnt_out); end
      checks++; if (pwm_out !== 4'b0010) begin errors++; $display("FAIL rst_p0_pwm j=%0d got %b exp 0010", j, pwm_out); end
      checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_p0_ready j=%0d got %b exp 1", j, upd_ready); end
      checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rst_p0_ps j=%0d got %b exp 1", j, period_start); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_edge_basic();
    test_shadow();
    test_simultaneous();
    test_center();
    test_inv_enable();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
